instruction_fetch_unit: RTL and testbench

- Initiator side of the instruction-memory ReadEnable/Ack protocol.
- Owns the fetch PC and issues one single-cycle ReadEnable pulse per request.
- Waits for the one-cycle Ack, then captures Instr into the F/D output register.
- Handles downstream stall (one-entry hold buffer) and branch/jump redirect, including discarding in-flight responses.

---
 rtl/fetch_pkg.sv | 22 ++
 rtl/fetch_hold_buffer.sv | 40 ++++
 rtl/instruction_fetch_unit.sv | 215 +++++++++++++++++++++
 tb/tb_instruction_fetch_unit.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// FETCH_TIMEOUT_EN (optional macro) enables the Ack watchdog in instruction_fetch_unit.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } fetch_state_t;

  localparam logic [31:0] RESET_PC_DEFAULT       = 32'h0000_0000;
  localparam int unsigned PC_STEP_DEFAULT        = 4;
  localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 16;
  localparam logic [31:0] ADDR_ALIGN_MASK        = 32'hFFFF_FFFC;

  // Redirect targets are word aligned by dropping the two low byte-address bits.
  function automatic logic [31:0] alignPc(input logic [31:0] pc);
    return pc & ADDR_ALIGN_MASK;
  endfunction

endpackage

// File: rtl/fetch_hold_buffer.sv
// One-entry instruction/PC buffer that parks a response while decode is stalled.
// Flush beats load, load beats unload.
module fetch_hold_buffer (
  input  logic        CLK,
  input  logic        RST,
  input  logic        i_load,
  input  logic        i_unload,
  input  logic        i_flush,
  input  logic [31:0] i_instr,
  input  logic [31:0] i_pc,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc,
  output logic        o_valid
);

  logic [31:0] r_instr;
  logic [31:0] r_pc;
  logic        r_valid;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_instr <= 32'h0;
      r_pc    <= 32'h0;
      r_valid <= 1'b0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_instr <= i_instr;
      r_pc    <= i_pc;
      r_valid <= 1'b1;
    end else if (i_unload) begin
      r_valid <= 1'b0;
    end
  end

  assign o_instr = r_instr;
  assign o_pc    = r_pc;
  assign o_valid = r_valid;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch PC owner and ReadEnable/Ack initiator feeding the F/D register.
// Define FETCH_TIMEOUT_EN to add the sticky Ack watchdog (FetchError).
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned PC_STEP  = PC_STEP_DEFAULT
`ifdef FETCH_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
`endif
) (
  input  logic        CLK,
  input  logic        RST,
  output logic [31:0] address,
  output logic        ReadEnable,
  input  logic        Ack,
  input  logic [31:0] Instr,
  input  logic        Stall,
  input  logic        Redirect,
  input  logic [31:0] RedirectPC,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic        ValidD,
  output logic        FetchError
);

  localparam logic [31:0] STEP = 32'(PC_STEP);

  fetch_state_t r_state, w_stateNext;
  logic [31:0]  r_addr, w_addrNext;
  logic         r_re, w_reNext;
  logic         r_drop, w_dropNext;
  logic [31:0]  r_pendPc, w_pendPcNext;
  logic [31:0]  r_instrD, w_instrDNext;
  logic [31:0]  r_pcD, w_pcDNext;
  logic         r_validD, w_validDNext;

  logic         w_holdLoad;
  logic         w_holdUnload;
  logic         w_holdFlush;
  logic [31:0]  w_holdInstr;
  logic [31:0]  w_holdPc;
  logic         w_holdValid;

  logic [31:0]  w_redirTarget;
  logic         w_outFree;
  logic         w_timeout;

  assign w_redirTarget = alignPc(RedirectPC);
  assign w_outFree     = !r_validD || !Stall;

  fetch_hold_buffer u_holdBuffer (
    .CLK      (CLK),
    .RST      (RST),
    .i_load   (w_holdLoad),
    .i_unload (w_holdUnload),
    .i_flush  (w_holdFlush),
    .i_instr  (Instr),
    .i_pc     (r_addr),
    .o_instr  (w_holdInstr),
    .o_pc     (w_holdPc),
    .o_valid  (w_holdValid)
  );

`ifdef FETCH_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] r_tmoCnt;
  logic          r_fetchErr;

  assign w_timeout = (r_state == WAIT) && !Ack && (r_tmoCnt == TMO_LAST);

  // Counts Ack-less WAIT cycles; every REQ cycle restarts the count.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_tmoCnt   <= '0;
      r_fetchErr <= 1'b0;
    end else begin
      if (r_state == REQ) begin
        r_tmoCnt <= '0;
      end else if ((r_state == WAIT) && !Ack) begin
        r_tmoCnt <= r_tmoCnt + TW'(1);
      end
      if (w_timeout) begin
        r_fetchErr <= 1'b1;
      end
    end
  end

  assign FetchError = r_fetchErr;
`else
  assign w_timeout  = 1'b0;
  assign FetchError = 1'b0;
`endif

  // The output register empties at a consuming edge unless something new lands;
  // Redirect overrides everything and flushes both output and hold entry.
  always_comb begin
    w_stateNext   = r_state;
    w_addrNext    = r_addr;
    w_reNext      = 1'b0;
    w_dropNext    = r_drop;
    w_pendPcNext  = r_pendPc;
    w_instrDNext  = r_instrD;
    w_pcDNext     = r_pcD;
    w_validDNext  = r_validD && Stall;
    w_holdLoad    = 1'b0;
    w_holdUnload  = 1'b0;
    w_holdFlush   = Redirect;

    if (Redirect) begin
      w_validDNext = 1'b0;
    end

    unique case (r_state)
      IDLE: begin
        w_reNext    = 1'b1;
        w_addrNext  = Redirect ? w_redirTarget : RESET_PC;
        w_stateNext = REQ;
      end

      REQ: begin
        w_stateNext = WAIT;
        if (Redirect) begin
          w_dropNext   = 1'b1;
          w_pendPcNext = w_redirTarget;
        end
      end

      WAIT: begin
        if (Ack) begin
          w_reNext    = 1'b1;
          w_stateNext = REQ;
          if (Redirect) begin
            w_addrNext = w_redirTarget;
            w_dropNext = 1'b0;
          end else if (r_drop) begin
            w_addrNext = r_pendPc;
            w_dropNext = 1'b0;
          end else if (w_outFree) begin
            w_instrDNext = Instr;
            w_pcDNext    = r_addr;
            w_validDNext = 1'b1;
            w_addrNext   = r_addr + STEP;
          end else begin
            w_holdLoad  = 1'b1;
            w_reNext    = 1'b0;
            w_stateNext = HOLD;
          end
        end else begin
          if (Redirect) begin
            w_dropNext   = 1'b1;
            w_pendPcNext = w_redirTarget;
          end
          // Watchdog expiry reissues the same address.
          if (w_timeout) begin
            w_reNext    = 1'b1;
            w_stateNext = REQ;
          end
        end
      end

      HOLD: begin
        if (Redirect) begin
          w_reNext    = 1'b1;
          w_addrNext  = w_redirTarget;
          w_stateNext = REQ;
        end else if (!Stall && w_holdValid) begin
          w_holdUnload = 1'b1;
          w_instrDNext = w_holdInstr;
          w_pcDNext    = w_holdPc;
          w_validDNext = 1'b1;
          w_reNext     = 1'b1;
          w_addrNext   = r_addr + STEP;
          w_stateNext  = REQ;
        end
      end

      default: begin
        w_stateNext = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state  <= IDLE;
      r_addr   <= RESET_PC;
      r_re     <= 1'b0;
      r_drop   <= 1'b0;
      r_pendPc <= 32'h0;
      r_instrD <= 32'h0;
      r_pcD    <= 32'h0;
      r_validD <= 1'b0;
    end else begin
      r_state  <= w_stateNext;
      r_addr   <= w_addrNext;
      r_re     <= w_reNext;
      r_drop   <= w_dropNext;
      r_pendPc <= w_pendPcNext;
      r_instrD <= w_instrDNext;
      r_pcD    <= w_pcDNext;
      r_validD <= w_validDNext;
    end
  end

  assign address    = r_addr;
  assign ReadEnable = r_re;
  assign InstrD     = r_instrD;
  assign PCD        = r_pcD;
  assign ValidD     = r_validD;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Randomized bench for instruction_fetch_unit with a program-order reference model
// and a variable-latency memory responder.
module tb_instruction_fetch_unit;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] address;
  logic        ReadEnable;
  logic        Ack = 1'b0;
  logic [31:0] Instr = 32'h0;
  logic        Stall;
  logic        Redirect;
  logic [31:0] RedirectPC;
  logic [31:0] InstrD;
  logic [31:0] PCD;
  logic        ValidD;
  logic        FetchError;

  int nChecks = 0;
  int nFail   = 0;

  int  ackMax   = 1;
  bit  withhold = 1'b0;
  bit  checkEn  = 1'b1;
  int  cycleCnt = 0;
  logic [31:0] reqLog[$];
  int          reqCyc[$];

  logic [31:0] ptr, dptr;
  logic [31:0] prevPcd, prevInstrD;
  bit prevValid = 0, prevStall = 0, prevRedirect = 0, prevRst = 0;
  int deliveries = 0;

  instruction_fetch_unit dut (
    .CLK        (CLK),
    .RST        (RST),
    .address    (address),
    .ReadEnable (ReadEnable),
    .Ack        (Ack),
    .Instr      (Instr),
    .Stall      (Stall),
    .Redirect   (Redirect),
    .RedirectPC (RedirectPC),
    .InstrD     (InstrD),
    .PCD        (PCD),
    .ValidD     (ValidD),
    .FetchError (FetchError)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at cycle %0d", name, act, exp, cycleCnt);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic applyStimulus();
    Stall    = ($urandom_range(0, 99) < 30);
    Redirect = ($urandom_range(0, 99) < 5);
    if ($urandom_range(0, 3) == 0) RedirectPC = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
    else RedirectPC = $urandom;
  endtask

  task automatic waitRE(input string name);
    int n = 0;
    while (!ReadEnable && n < 40) begin
      tick();
      n++;
    end
    checkOutput(name, ReadEnable, 1);
  endtask

  task automatic waitValid(input string name);
    int n = 0;
    while (!ValidD && n < 40) begin
      tick();
      n++;
    end
    checkOutput(name, ValidD, 1);
  endtask

  task automatic redirectTo(input logic [31:0] pc);
    Redirect   = 1'b1;
    RedirectPC = pc;
    tick();
    Redirect   = 1'b0;
  endtask

  // Memory responder: each request is answered by one Ack 1..ackMax cycles later.
  initial begin
    bit outstanding = 0;
    bit prevRE = 0;
    int cnt = 0;
    logic [31:0] reqA = 32'h0;
    forever begin
      @(posedge CLK);
      #1;
      cycleCnt++;
      Ack   = 1'b0;
      Instr = $urandom;
      if (RST) begin
        outstanding = 0;
        prevRE      = 0;
      end else begin
        if (outstanding && !withhold) begin
          cnt--;
          if (cnt == 0) begin
            Ack         = 1'b1;
            Instr       = memf(reqA);
            outstanding = 0;
          end
        end
        if (ReadEnable) begin
          checkOutput("reBackToBack", 32'(prevRE), 0);
          checkOutput("reWithAck", 32'(Ack), 0);
          checkOutput("reOutstanding", 32'(outstanding && !withhold), 0);
          outstanding = 1;
          reqA        = address;
          cnt         = $urandom_range(1, ackMax);
          reqLog.push_back(address);
          reqCyc.push_back(cycleCnt);
        end
        prevRE = ReadEnable;
      end
    end
  end

  // Program-order model: requests walk a fetch pointer, deliveries walk a decode
  // pointer; a redirect retargets both and must blank the next output cycle.
  always @(negedge CLK) begin
    if (checkEn) begin
      if (prevRst) begin
        checkOutput("rstReadEnable", ReadEnable, 0);
        checkOutput("rstAddress", address, 32'h0);
        checkOutput("rstValidD", ValidD, 0);
        checkOutput("rstInstrD", InstrD, 32'h0);
        checkOutput("rstPcd", PCD, 32'h0);
        checkOutput("rstFetchError", FetchError, 0);
      end
      if (RST) begin
        ptr          = 32'h0;
        dptr         = 32'h0;
        prevValid    = 0;
        prevStall    = 0;
        prevRedirect = 0;
      end else begin
        if (ReadEnable) begin
          checkOutput("reqAddr", address, ptr);
          ptr = ptr + 32'd4;
        end
        if (prevRedirect) begin
          checkOutput("flushValid", ValidD, 0);
        end else if (ValidD && (!prevValid || !prevStall)) begin
          checkOutput("dlvPc", PCD, dptr);
          checkOutput("dlvInstr", InstrD, memf(PCD));
          dptr = dptr + 32'd4;
          deliveries++;
        end else if (ValidD) begin
          checkOutput("heldPc", PCD, prevPcd);
          checkOutput("heldInstr", InstrD, prevInstrD);
        end
        if (Redirect) begin
          ptr  = RedirectPC & 32'hFFFF_FFFC;
          dptr = RedirectPC & 32'hFFFF_FFFC;
        end
        prevValid    = ValidD;
        prevStall    = Stall;
        prevRedirect = Redirect;
        prevPcd      = PCD;
        prevInstrD   = InstrD;
      end
      prevRst = RST;
    end
  end

  initial begin
    int cyc;
    int nReq;
    logic [31:0] pcs;

    RST        = 1'b1;
    Stall      = 1'b0;
    Redirect   = 1'b0;
    RedirectPC = 32'h0;
    repeat (3) tick();
    RST = 1'b0;

    cyc = 0;
    while (!ValidD && cyc < 20) begin
      tick();
      cyc++;
    end
    checkOutput("firstValidEdges", 32'(cyc), 32'd3);
    checkOutput("firstPcd", PCD, 32'h0);
    checkOutput("firstInstr", InstrD, 32'h5A5A_0F0F);
    repeat (6) tick();
    checkOutput("reqCount", 32'(reqLog.size() >= 4), 1);
    if (reqLog.size() >= 4) begin
      for (int i = 0; i < 4; i++) checkOutput("seqAddr", reqLog[i], 32'(i * 4));
      checkOutput("rePeriod", 32'(reqCyc[3] - reqCyc[2]), 32'd2);
    end

    waitValid("stallStartValid");
    Stall = 1'b1;
    pcs   = PCD;
    nReq  = reqLog.size();
    repeat (5) tick();
    checkOutput("stallNoReq", 32'(reqLog.size() - nReq <= 1), 1);
    checkOutput("stallHeldPc", PCD, pcs);
    Stall = 1'b0;
    tick();
    checkOutput("stallReleasePc", PCD, pcs + 32'd4);
    checkOutput("stallReleaseRe", ReadEnable, 1);
    checkOutput("stallReleaseAddr", address, pcs + 32'd8);

    tick();
    waitRE("redirReqSeen");
    redirectTo(32'h40);
    waitRE("redirReqNext");
    checkOutput("redirReqAddr", address, 32'h40);
    waitValid("redirReqDlv0");
    checkOutput("redirReqPcd0", PCD, 32'h40);
    tick();
    waitValid("redirReqDlv1");
    checkOutput("redirReqPcd1", PCD, 32'h44);

    cyc = 0;
    while (!Ack && cyc < 40) begin
      tick();
      cyc++;
    end
    checkOutput("ackSeen", Ack, 1);
    redirectTo(32'h80);
    checkOutput("redirAckRe", ReadEnable, 1);
    checkOutput("redirAckAddr", address, 32'h80);
    checkOutput("redirAckValid", ValidD, 0);

    redirectTo(32'h103);
    waitRE("alignRe");
    checkOutput("alignAddr", address, 32'h100);
    redirectTo(32'hFFFF_FFFF);
    waitRE("wrapRe0");
    checkOutput("wrapAddr0", address, 32'hFFFF_FFFC);
    tick();
    waitRE("wrapRe1");
    checkOutput("wrapAddr1", address, 32'h0);

    tick();
    RST = 1'b1;
    tick();
    checkOutput("midRstAddr", address, 32'h0);
    checkOutput("midRstValid", ValidD, 0);
    RST = 1'b0;

    ackMax = 3;
    for (int i = 0; i < 3000; i++) begin
      applyStimulus();
      tick();
    end
    Stall    = 1'b0;
    Redirect = 1'b0;
    repeat (10) tick();
    checkOutput("liveness", 32'(deliveries >= 100), 1);

`ifdef FETCH_TIMEOUT_EN
    ackMax = 1;
    waitRE("tmoReSeen");
    checkEn  = 1'b0;
    withhold = 1'b1;
    pcs = address;
    cyc = 0;
    tick();
    cyc++;
    while (!FetchError && cyc < 40) begin
      tick();
      cyc++;
    end
    checkOutput("tmoEdges", 32'(cyc), 32'd17);
    checkOutput("tmoReissue", ReadEnable, 1);
    checkOutput("tmoSameAddr", address, pcs);
    repeat (3) tick();
    checkOutput("tmoSticky", FetchError, 1);
    checkEn = 1'b1;
    RST     = 1'b1;
    tick();
    checkOutput("tmoRstErr", FetchError, 0);
    checkOutput("tmoRstAddr", address, 32'h0);
    withhold = 1'b0;
    RST      = 1'b0;
    repeat (20) tick();
`else
    checkOutput("noFetchError", FetchError, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFail);
    $finish;
  end

endmodule
